// File: rtl/arith_serial_sched.sv
// arith_serial_sched: two-client round-robin front end for a shared
// bit-serial arithmetic cell (ADD / SUB / AND / XOR), LSB first, W cycles
// per operation, W+2 cycles per service slot.
module arith_serial_sched #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic [W-1:0] result,
   output logic         carry
);

   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_t;

   state_t         state_q,  state_d;
   op_t            op_q,     op_d;
   logic [W-1:0]   a_sh_q,   a_sh_d;
   logic [W-1:0]   b_sh_q,   b_sh_d;
   logic [W-1:0]   res_sh_q, res_sh_d;
   logic [CW-1:0]  cnt_q,    cnt_d;
   logic           cy_q,     cy_d;
   logic           id_q,     id_d;
   logic           last_q,   last_d;
   logic [W-1:0]   result_q, result_d;
   logic           carry_q,  carry_d;
   logic           done_id_q, done_id_d;

   logic           a_bit;
   logic           b_bit;
   logic           s_bit;
   logic           c_next;

   // Round-robin grant, only offered in IDLE and never during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && state_q == S_IDLE) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // One-bit arithmetic cell; SUB is ADD with b inverted and carry-in 1.
   always_comb begin
      a_bit  = a_sh_q[0];
      b_bit  = (op_q == OP_SUB) ? ~b_sh_q[0] : b_sh_q[0];
      s_bit  = 1'b0;
      c_next = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            s_bit  = a_bit ^ b_bit ^ cy_q;
            c_next = (a_bit & b_bit) | (a_bit & cy_q) | (b_bit & cy_q);
         end
         OP_AND: s_bit = a_bit & b_bit;
         OP_XOR: s_bit = a_bit ^ b_bit;
         default: ;
      endcase
   end

   // Next-state and datapath sequencing.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      res_sh_d  = res_sh_q;
      cnt_d     = cnt_q;
      cy_d      = cy_q;
      id_d      = id_q;
      last_d    = last_q;
      result_d  = result_q;
      carry_d   = carry_q;
      done_id_d = done_id_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               op_d     = gnt1 ? op_t'(op1) : op_t'(op0);
               a_sh_d   = gnt1 ? a1 : a0;
               b_sh_d   = gnt1 ? b1 : b0;
               cy_d     = ((gnt1 ? op1 : op0) == OP_SUB);
               id_d     = gnt1;
               res_sh_d = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = {1'b0, a_sh_q[W-1:1]};
            b_sh_d   = {1'b0, b_sh_q[W-1:1]};
            res_sh_d = {s_bit, res_sh_q[W-1:1]};
            cy_d     = c_next;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               // Outputs are registered on the edge entering DONE so they
               // change together with the rising done pulse.
               result_d  = {s_bit, res_sh_q[W-1:1]};
               carry_d   = c_next;
               done_id_d = id_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            last_d  = id_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ADD;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         res_sh_q  <= '0;
         cnt_q     <= '0;
         cy_q      <= 1'b0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         result_q  <= '0;
         carry_q   <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         res_sh_q  <= res_sh_d;
         cnt_q     <= cnt_d;
         cy_q      <= cy_d;
         id_q      <= id_d;
         last_q    <= last_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         done_id_q <= done_id_d;
      end
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      result  = result_q;
      carry   = carry_q;
      done_id = done_id_q;
   end

endmodule

// File: tb/tb_arith_serial_sched.sv
// Directed bench for arith_serial_sched (W = 8).
module tb_arith_serial_sched;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [1:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         gnt0, gnt1, busy, done, done_id, carry;
   logic [W-1:0] result;

   int checks   = 0;
   int failures = 0;

   arith_serial_sched #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .busy(busy), .done(done), .done_id(done_id),
      .result(result), .carry(carry)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Raise one client's request in IDLE and expect its grant this cycle.
   task automatic start_job(input bit id);
      if (id) req1 = 1'b1; else req0 = 1'b1;
      #1;
      chk("start_gnt0", gnt0, !id);
      chk("start_gnt1", gnt1, id);
   endtask

   // Called in grant cycle 0; returns at the sample point of cycle W+2.
   task automatic finish_job(input string tag, input bit id, input logic [W-1:0] er,
                             input bit ec, input bit drop, input int raise_at);
      int cyc;
      tick();
      cyc = 1;
      if (drop) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      while (done !== 1'b1 && cyc < 20) begin
         if (cyc == raise_at) req1 = 1'b1;
         #1;
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_nogrant"}, {gnt0, gnt1}, 2'b00);
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, cyc, W + 1);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_done"}, busy, 1'b1);
      chk({tag, "_result"}, result, er);
      chk({tag, "_carry"}, carry, ec);
      chk({tag, "_id"}, done_id, id);
      tick();
      chk({tag, "_done_low"}, done, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_hold"}, result, er);
   endtask

   initial begin
      // Reset held two cycles with both requests high
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      op0 = 2'b00; a0 = 8'd200; b0 = 8'd100;
      op1 = 2'b01; a1 = 8'd5;   b1 = 8'd7;
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         chk("rst_gnt", {gnt0, gnt1}, 2'b00);
         chk("rst_busy", busy, 1'b0);
         chk("rst_done", done, 1'b0);
         chk("rst_result", result, 8'd0);
         chk("rst_carry", carry, 1'b0);
         chk("rst_done_id", done_id, 1'b0);
      end
      rst = 1'b0;
      #1;
      chk("tie_first_gnt0", gnt0, 1'b1);
      chk("tie_first_gnt1", gnt1, 1'b0);
      req1 = 1'b0;
      // ADD 200 + 100 = 300 -> 44, carry 1
      finish_job("add", 1'b0, 8'd44, 1'b1, 1'b1, 0);

      // SUB 5 - 7 -> 254, borrow
      start_job(1'b1);
      finish_job("sub_neg", 1'b1, 8'd254, 1'b0, 1'b1, 0);
      // SUB 7 - 5 -> 2, no borrow
      a1 = 8'd7; b1 = 8'd5;
      start_job(1'b1);
      finish_job("sub_pos", 1'b1, 8'd2, 1'b1, 1'b1, 0);

      // Round-robin with both requests held high
      op0 = 2'b10; a0 = 8'hF0; b0 = 8'h3C;
      op1 = 2'b11; a1 = 8'hF0; b1 = 8'h3C;
      req0 = 1'b1; req1 = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("rr_gnt0", gnt0, (j % 2) == 0);
         chk("rr_gnt1", gnt1, (j % 2) == 1);
         if ((j % 2) == 0)
            finish_job("rr_and", 1'b0, 8'h30, 1'b0, j == 3, 0);
         else
            finish_job("rr_xor", 1'b1, 8'hCC, 1'b0, j == 3, 0);
      end

      // req1 raised during RUN cycle 3 of a client-0 job stays pending
      op0 = 2'b00; a0 = 8'd10;  b0 = 8'd20;
      op1 = 2'b00; a1 = 8'd100; b1 = 8'd155;
      start_job(1'b0);
      finish_job("pend0", 1'b0, 8'd30, 1'b0, 1'b1, 3);
      #1;
      chk("pend_gnt1", gnt1, 1'b1);
      chk("pend_gnt0", gnt0, 1'b0);
      finish_job("pend1", 1'b1, 8'd255, 1'b0, 1'b1, 0);

      // Reset during RUN cycle 4 aborts the job
      a0 = 8'd3; b0 = 8'd4;
      start_job(1'b0);
      tick();
      req0 = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, 8'd0);
      chk("abort_carry", carry, 1'b0);
      chk("abort_done_id", done_id, 1'b0);
      for (int k = 0; k < 10; k++) begin
         chk("abort_no_done", done, 1'b0);
         chk("abort_result_hold", result, 8'd0);
         tick();
      end
      a0 = 8'd1; b0 = 8'd1;
      start_job(1'b0);
      finish_job("abort_add", 1'b0, 8'd2, 1'b0, 1'b1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arith_serial_sched.md
# arith_serial_sched

Shared bit-serial arithmetic engine with a two-requester round-robin scheduler. It accepts W-bit operand pairs and an opcode from two clients and grants one client at a time. It then sequences a 1-bit arithmetic cell (sum/carry) over W cycles, LSB first, and returns the W-bit result, a carry/borrow flag and the serviced client's ID. It sits between the client-side control logic and the single-bit arithmetic datapath, which it time-multiplexes.

## Interface
- W, default 8: operand/result width; W ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  request from client 0 / client 1; held high with stable operands until the matching gnt.
- op0, op1  in  2  opcode: 00 ADD, 01 SUB (a−b), 10 AND, 11 XOR.
- a0, b0, a1, b1  in  W  operands per client.
- gnt0, gnt1  out  1  one-cycle grant; operands/opcode sampled at the clock edge ending this cycle.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  client serviced by the current/last done.
- result  out  W  result; valid from done, held until the next done.
- carry  out  1  ADD: carry-out; SUB: 1 = no borrow (a ≥ b); AND/XOR: 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - gnt is combinational: if exactly one req is high, grant that client.
  - If both are high, grant the client not served last. The last-served pointer resets to 1, so client 0 wins the first tie.
  - On a grant, load the A and B shift registers and the op/id registers. Load carry_reg = 1 for SUB and 0 otherwise. Clear the bit counter. Go to RUN.
- RUN: one bit per cycle.
  - ADD: s = a^b^c, c' = maj(a,b,c).
  - SUB: same as ADD with b inverted (a + ~b + 1).
  - AND/XOR: bitwise, carry_reg held at 0.
  - Shift the result bit into the MSB of the result shift register. The shift is right, so after W shifts bit 0 is at the LSB.
  - The counter runs 0..W−1. At W−1, go to DONE.
- DONE:
  - Copy the result shift register to result, carry_reg to carry, and id to done_id.
  - Pulse done and update the last-served pointer.
  - Go to IDLE.
- No grant is issued outside IDLE. Requests raised while busy stay pending and are serviced once back in IDLE.
- A req dropped before its grant has no effect and is not remembered.
- Arithmetic is modulo 2^W; overflow is visible only through carry.

## Timing
- Let cycle 0 be the cycle with gnt high; operands are captured at the end of cycle 0.
- RUN occupies cycles 1..W. done is high in cycle W+1.
- result, carry and done_id change at the same edge that raises done, and hold until the next done.
- The next gnt comes no earlier than cycle W+2 (back in IDLE). Service period is W+2 cycles.
- Reset values:
  - State IDLE; pointer = 1.
  - gnt0 = gnt1 = busy = done = done_id = carry = 0; result = 0.
- Reset mid-operation: the next cycle is IDLE with every output at its reset value. The aborted job produces no done.
- The gnt outputs are 0 in the reset cycle even if req is high.
- Simultaneous req0 and req1: exactly one gnt. The two gnts are never high together.

## Test plan
- Reset: hold rst 2 cycles with both req high → gnt0 = gnt1 = busy = done = 0, result = 0, carry = 0. Release rst → gnt0 in the first IDLE cycle.
- ADD, W=8: req0, op0 = 00, a0 = 200, b0 = 100.
  - gnt0 in cycle 0, busy in cycles 1–9, done in cycle 9.
  - result = 44, carry = 1, done_id = 0.
- SUB:
  - req1, op1 = 01, a1 = 5, b1 = 7 → result = 254, carry = 0, done_id = 1.
  - a1 = 7, b1 = 5 → result = 2, carry = 1.
- Round-robin: req0 and req1 both held high.
  - Client 0: op = 10, 0xF0 and 0x3C. Client 1: op = 11, same operands.
  - Grants alternate 0,1,0,1; first grant to 0; grants spaced 10 cycles apart.
  - Results alternate 0x30 (carry 0) and 0xCC (carry 0).
- Pending request: raise req1 during RUN cycle 3 of a client-0 job.
  - No gnt1 before client 0's done.
  - gnt1 in the cycle after done; its done arrives 9 cycles later.
- Abort: assert rst for one cycle during RUN cycle 4.
  - No done; busy = 0 the next cycle; result stays 0.
  - A subsequent ADD of 1 + 1 returns 2, carry 0.
